fetch_line_queue: RTL and testbench
===================================

# fetch_line_queue

Parametrised instruction-fetch front end for the RISC-V core. It fetches whole cache lines over the Sysbus with multi-beat read bursts and unpacks each beat into 32-bit instruction words. Words go into an instruction queue, and the decode stage drains that queue through a valid/ready port. The block adds PC redirect with in-flight burst draining, unaligned entry, and halt on an all-zero instruction word.

## Interface
Parameters:
- BUS_DATA_WIDTH, 64, bus beat width; multiple of 32.
- BUS_TAG_WIDTH, 13, Sysbus tag width.
- LINE_BYTES, 64, bytes per fetch burst; power of two.
- QUEUE_DEPTH, 32, instruction queue entries; power of two, ≥ LINE_BYTES/4.

Ports:
- clk  in  1  clock; the block uses only this clock.
- reset  in  1  synchronous, active-high reset.
- entry  in  64  program entry PC, sampled while reset is high.
- bus_reqcyc  out  1  read request valid.
- bus_req  out  BUS_DATA_WIDTH  line-aligned request address.
- bus_reqtag  out  BUS_TAG_WIDTH  constant `SYSBUS_READ<<12 | `SYSBUS_MEMORY<<8.
- bus_reqack  in  1  request accepted.
- bus_respcyc  in  1  response beat valid.
- bus_resp  in  BUS_DATA_WIDTH  response beat data.
- bus_resptag  in  BUS_TAG_WIDTH  response tag; ignored.
- bus_respack  out  1  beat consumed.
- redirect_valid  in  1  new fetch PC from the back end.
- redirect_pc  in  64  redirect target; 4-byte aligned.
- inst_valid  out  1  queue head valid.
- inst_ready  in  1  decode accepts the head.
- inst_data  out  32  head instruction word.
- inst_pc  out  64  head instruction PC.
- halted  out  1  a zero word was reached and the queue is empty.

## Operation
Derived constants:
- W = BUS_DATA_WIDTH/32 words per beat.
- BEATS = LINE_BYTES*8/BUS_DATA_WIDTH beats per line.
- LW = LINE_BYTES/4 words per line.

Registers:
- fpc: next PC to fetch.
- skip: words to drop at the start of the current line.
- beat counter.

States:
- IDLE: a request is issued only when fpc is not halted and queue free ≥ LW, so every beat can always be accepted. Set bus_req = fpc & ~(LINE_BYTES-1) and skip = fpc[log2(LINE_BYTES)-1:2]. Go to REQ.
- REQ: hold bus_reqcyc high with bus_req stable until bus_reqack. Then go to RESP with beat = 0.
- RESP: each bus_respcyc beat is consumed that cycle.
  - Word k of the beat is bus_resp[32k+31:32k], little-end first; its line index is beat*W+k.
  - Words with index < skip are dropped.
  - Remaining words are enqueued in order, each with its PC.
  - After beat BEATS-1: fpc = line base + LINE_BYTES; go to IDLE.
- DRAIN: ack and discard the remaining beats of the burst, then go to IDLE.
- HALT: no further requests.

Zero word: the first in-order enqueuable word equal to 0 is not enqueued. Later words of the burst are discarded, the burst is still fully acked, and the FSM ends in HALT. halted = HALT && queue empty.

Redirect (any state, highest priority):
- Queue is flushed; fpc = redirect_pc; HALT is cleared.
- IDLE: next state IDLE.
- REQ: complete the ack with the old address, then DRAIN.
- RESP: the beat in the redirect cycle is acked and discarded. If it was the last beat, go to IDLE; otherwise go to DRAIN.
- inst_valid is forced to 0 during the redirect cycle.

## Timing
- bus_respack = bus_respcyc when in RESP or DRAIN (combinational).
- Reset values:
  - All outputs are 0.
  - fpc = entry; state = IDLE; queue empty.
- First bus_reqcyc is asserted in the first cycle after reset deasserts.
- Beat accepted in cycle t → its words are visible at the queue head no earlier than t+1. inst_data/inst_pc come from combinational read of the head.
- Dequeue happens when inst_valid && inst_ready. Enqueue and dequeue may occur in the same cycle; the free count is checked before that cycle's dequeue.
- Reset mid-burst: outstanding beats arriving after reset are acked and discarded, because reset enters DRAIN when the previous state was RESP.

## Structure
- Package fetch_pkg holds:
  - state enum {IDLE, REQ, RESP, DRAIN, HALT};
  - the read-tag constant built from the Sysbus.defs values;
  - functions for W, BEATS, LW.
- Sub-module fetch_queue: synchronous FIFO of {pc, word} entries.
  - Writes up to W entries per cycle via a write-enable mask.
  - One read per cycle.
  - Synchronous flush; occupancy output.
  - Pointers wrap modulo QUEUE_DEPTH with an extra wrap bit for full/empty.

## Test plan
- Aligned entry: entry=0x1000, 8 beats of nonzero pairs, inst_ready=1 → one request at 0x1000; 16 words with PCs 0x1000..0x103C in order; next request at 0x1040.
- Unaligned entry: entry=0x1018 → request 0x1000; first inst_pc = 0x1018; 10 words enqueued.
- Backpressure: inst_ready=0, QUEUE_DEPTH=32 → two lines fetched; third request withheld until ≥16 entries free.
- Redirect mid-burst: redirect_pc=0x2004 at beat 3 → queue empty next cycle; beats 3–7 acked and discarded; next request 0x2000; first inst_pc = 0x2004.
- Zero word: beat 2 high word = 0 → 5 words enqueued; remaining beats acked; no new request; halted=1 once drained; a redirect restarts fetch.
- Reset during RESP → outputs 0; stray beats acked; fresh request at the new entry.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and derived-size helpers for the line-fetch front end.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RESP,
    DRAIN,
    HALT
  } fetch_state_e;

  // Sysbus command encodings (from Sysbus.defs)
  localparam logic       SYSBUS_READ   = 1'b1;
  localparam logic [3:0] SYSBUS_MEMORY = 4'b0001;
  localparam int unsigned READ_TAG =
    (32'(SYSBUS_READ) << 12) | (32'(SYSBUS_MEMORY) << 8);

  function automatic int words_per_beat(input int bus_width);
    return bus_width / 32;
  endfunction

  function automatic int beats_per_line(input int line_bytes, input int bus_width);
    return line_bytes * 8 / bus_width;
  endfunction

  function automatic int words_per_line(input int line_bytes);
    return line_bytes / 4;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Instruction FIFO of {pc, word} entries: up to NW writes and one read per cycle.
module fetch_queue #(
  parameter int DEPTH = 32,
  parameter int NW    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [NW-1:0]             wr_en,
  input  logic [NW-1:0][63:0]       wr_pc,
  input  logic [NW-1:0][31:0]       wr_word,
  input  logic                      rd_en,
  output logic [63:0]               rd_pc,
  output logic [31:0]               rd_word,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   n_wr;
  logic [AW-1:0] slot [NW];
  logic [63:0]   pc_mem   [DEPTH];
  logic [31:0]   word_mem [DEPTH];

  // enabled lanes are packed into consecutive slots
  always_comb begin
    n_wr = '0;
    for (int k = 0; k < NW; k++) begin
      slot[k] = wr_ptr[AW-1:0] + n_wr[AW-1:0];
      if (wr_en[k]) n_wr = n_wr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NW; k++) begin
      if (wr_en[k] && !flush) begin
        pc_mem[slot[k]]   <= wr_pc[k];
        word_mem[slot[k]] <= wr_word[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + n_wr;
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign rd_pc   = pc_mem[rd_ptr[AW-1:0]];
  assign rd_word = word_mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/fetch_line_queue.sv
// Instruction fetch front end: line bursts over Sysbus, unpacked into an instruction queue.
// state | meaning
// IDLE  | waiting for queue room to issue the next line request
// REQ   | request held on the bus until acked
// RESP  | consuming beats of the current line into the queue
// DRAIN | acking and discarding the rest of an abandoned burst
// HALT  | zero word reached; no more requests until redirect
module fetch_line_queue
  import fetch_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int LINE_BYTES     = 64,
  parameter int QUEUE_DEPTH    = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [63:0]               entry,
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack,
  input  logic                      redirect_valid,
  input  logic [63:0]               redirect_pc,
  output logic                      inst_valid,
  input  logic                      inst_ready,
  output logic [31:0]               inst_data,
  output logic [63:0]               inst_pc,
  output logic                      halted
);

  localparam int W     = words_per_beat(BUS_DATA_WIDTH);
  localparam int BEATS = beats_per_line(LINE_BYTES, BUS_DATA_WIDTH);
  localparam int LW    = words_per_line(LINE_BYTES);
  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int IW    = OFF_W - 2;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW    = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [63:0] LINE_MASK = ~64'(LINE_BYTES - 1);

  fetch_state_e state, state_nx, rst_state;

  logic [63:0]         fpc;
  logic [63:0]         req_addr;
  logic [IW-1:0]       skip;
  logic [BW-1:0]       beat;
  logic                stop_seen;
  logic                drop_burst;
  logic                req_go;
  logic                last_beat;
  logic                zero_hit;
  logic                can_req;
  logic [W-1:0]        wr_en;
  logic [W-1:0][63:0]  wr_pc;
  logic [W-1:0][31:0]  wr_word;
  logic                q_empty;
  logic [CW-1:0]       q_count;
  logic                unused_resptag;

  assign unused_resptag = ^bus_resptag;
  assign last_beat      = (beat == BW'(BEATS - 1));
  assign can_req        = (q_count <= CW'(QUEUE_DEPTH - LW));

  always_ff @(posedge clk) begin
    if (reset) state <= rst_state;
    else       state <= state_nx;
  end

  always_comb begin
    rst_state = IDLE;
    if ((state == RESP || state == DRAIN) && !(bus_respcyc && last_beat))
      rst_state = DRAIN;
    state_nx = state;
    if (redirect_valid) begin
      case (state)
        REQ:         state_nx = bus_reqack ? DRAIN : REQ;
        RESP, DRAIN: state_nx = (bus_respcyc && last_beat) ? IDLE : DRAIN;
        default:     state_nx = IDLE;
      endcase
    end else begin
      case (state)
        IDLE:  if (req_go) state_nx = bus_reqack ? RESP : REQ;
        REQ:   if (bus_reqack) state_nx = drop_burst ? DRAIN : RESP;
        RESP:  if (bus_respcyc && last_beat) state_nx = (stop_seen || zero_hit) ? HALT : IDLE;
        DRAIN: if (bus_respcyc && last_beat) state_nx = IDLE;
        default: state_nx = state;
      endcase
    end
  end

  always_comb begin
    req_go      = (state == IDLE) && !reset && !redirect_valid && can_req;
    bus_reqcyc  = req_go || ((state == REQ) && !reset);
    bus_req     = '0;
    bus_reqtag  = '0;
    if (bus_reqcyc) begin
      bus_req    = BUS_DATA_WIDTH'((state == REQ) ? req_addr : (fpc & LINE_MASK));
      bus_reqtag = BUS_TAG_WIDTH'(READ_TAG);
    end
    bus_respack = bus_respcyc && (state == RESP || state == DRAIN);
    inst_valid  = !q_empty && !redirect_valid && !reset;
    halted      = (state == HALT) && q_empty && !reset;
  end

  // unpack a beat: skip leading words, stop at the first zero word
  always_comb begin
    wr_en    = '0;
    zero_hit = 1'b0;
    for (int k = 0; k < W; k++) begin
      wr_word[k] = bus_resp[32*k +: 32];
      wr_pc[k]   = req_addr + 64'((int'(beat) * W + k) * 4);
    end
    if (state == RESP && bus_respcyc && !redirect_valid && !reset && !stop_seen) begin
      for (int k = 0; k < W; k++) begin
        if (!zero_hit && (int'(beat) * W + k) >= int'(skip)) begin
          if (wr_word[k] == 32'd0) zero_hit = 1'b1;
          else                     wr_en[k] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset && !(state == RESP || state == DRAIN)) beat <= '0;
    else if (bus_respack) beat <= last_beat ? '0 : beat + BW'(1);

    if (reset) begin
      fpc        <= entry;
      req_addr   <= '0;
      skip       <= '0;
      stop_seen  <= 1'b0;
      drop_burst <= 1'b0;
    end else if (redirect_valid) begin
      fpc        <= redirect_pc;
      stop_seen  <= 1'b0;
      drop_burst <= (state == REQ) && !bus_reqack;
    end else begin
      if (req_go) begin
        req_addr <= fpc & LINE_MASK;
        skip     <= fpc[OFF_W-1:2];
      end
      if (state == RESP) begin
        if (zero_hit) stop_seen <= 1'b1;
        if (bus_respcyc && last_beat && !stop_seen && !zero_hit)
          fpc <= req_addr + 64'(LINE_BYTES);
      end else begin
        stop_seen <= 1'b0;
      end
      if (state == REQ && bus_reqack) drop_burst <= 1'b0;
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .NW    (W)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .flush   (redirect_valid),
    .wr_en   (wr_en),
    .wr_pc   (wr_pc),
    .wr_word (wr_word),
    .rd_en   (inst_valid && inst_ready),
    .rd_pc   (inst_pc),
    .rd_word (inst_data),
    .empty   (q_empty),
    .count   (q_count)
  );

endmodule

// File: tb/tb_fetch_line_queue.sv
// Scoreboard bench for fetch_line_queue: directed bursts, expected words queued, monitor compares.
module tb_fetch_line_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] entry = 64'h1000;
  logic        bus_reqcyc;
  logic [63:0] bus_req;
  logic [12:0] bus_reqtag;
  logic        bus_reqack = 1'b0;
  logic        bus_respcyc = 1'b0;
  logic [63:0] bus_resp = '0;
  logic [12:0] bus_resptag = '0;
  logic        bus_respack;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [63:0] inst_pc;
  logic        halted;

  int tests = 0;
  int fails = 0;
  int pops  = 0;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] word;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  fetch_line_queue dut (
    .clk(clk), .reset(reset), .entry(entry),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
    .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp),
    .bus_resptag(bus_resptag), .bus_respack(bus_respack),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc), .halted(halted)
  );

  function automatic logic [31:0] wval(input logic [63:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  always @(negedge clk) begin
    if (inst_valid && inst_ready) begin
      exp_t e;
      pops++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL inst_unexpected: got pc=%h data=%h, expected no instruction", inst_pc, inst_data);
      end else begin
        e = exp_q.pop_front();
        if (inst_pc !== e.pc || inst_data !== e.word) begin
          fails++;
          $display("FAIL inst: got pc=%h data=%h, expected pc=%h data=%h", inst_pc, inst_data, e.pc, e.word);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [63:0] base, input int from, input int to);
    for (int i = from; i <= to; i++)
      exp_q.push_back('{pc: base + 64'(4 * i), word: wval(base + 64'(4 * i))});
  endtask

  task automatic do_reset(input logic [63:0] e);
    reset = 1'b1;
    entry = e;
    redirect_valid = 1'b0;
    bus_respcyc = 1'b0;
    bus_reqack = 1'b0;
    repeat (3) tick();
    check("rst_inst_valid", inst_valid, 0);
    check("rst_reqcyc", bus_reqcyc, 0);
    check("rst_halted", halted, 0);
    reset = 1'b0;
    pops = 0;
    #1;
    check("first_req_after_reset", bus_reqcyc, 1);
  endtask

  task automatic wait_req(input logic [63:0] addr);
    int n = 0;
    while (!bus_reqcyc && n < 300) begin
      tick();
      n++;
    end
    check("req_seen", bus_reqcyc, 1);
    check("req_addr", bus_req, addr);
    check("req_tag", bus_reqtag, 64'h1100);
  endtask

  task automatic do_ack();
    bus_reqack = 1'b1;
    tick();
    bus_reqack = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] base, input int b, input int zero_idx);
    logic [31:0] w0, w1;
    w0 = (2 * b == zero_idx)     ? 32'd0 : wval(base + 64'(8 * b));
    w1 = (2 * b + 1 == zero_idx) ? 32'd0 : wval(base + 64'(8 * b + 4));
    bus_respcyc = 1'b1;
    bus_resp = {w1, w0};
    #1;
    check("respack", bus_respack, 1);
    @(posedge clk);
    #1;
    bus_respcyc = 1'b0;
  endtask

  task automatic drain_wait();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    check("scoreboard_drained", 64'(exp_q.size()), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int seen;

    // aligned entry
    inst_ready = 1'b1;
    do_reset(64'h1000);
    push_exp(64'h1000, 0, 15);
    wait_req(64'h1000);
    do_ack();
    for (int b = 0; b < 8; b++) send_beat(64'h1000, b, -1);
    wait_req(64'h1040);
    drain_wait();

    // unaligned entry
    do_reset(64'h1018);
    push_exp(64'h1000, 6, 15);
    wait_req(64'h1000);
    do_ack();
    for (int b = 0; b < 8; b++) send_beat(64'h1000, b, -1);
    wait_req(64'h1040);
    drain_wait();
    check("unaligned_count", 64'(pops), 10);

    // backpressure
    inst_ready = 1'b0;
    do_reset(64'h1000);
    push_exp(64'h1000, 0, 15);
    push_exp(64'h1040, 0, 15);
    wait_req(64'h1000);
    do_ack();
    for (int b = 0; b < 8; b++) send_beat(64'h1000, b, -1);
    wait_req(64'h1040);
    do_ack();
    for (int b = 0; b < 8; b++) send_beat(64'h1040, b, -1);
    seen = 0;
    repeat (20) begin
      tick();
      if (bus_reqcyc) seen = 1;
    end
    check("third_req_withheld", 64'(seen), 0);
    pops = 0;
    inst_ready = 1'b1;
    wait_req(64'h1080);
    check("pops_before_third_req", 64'(pops), 16);
    push_exp(64'h1080, 0, 15);
    do_ack();
    for (int b = 0; b < 8; b++) send_beat(64'h1080, b, -1);
    drain_wait();

    // redirect mid-burst
    inst_ready = 1'b0;
    do_reset(64'h1000);
    wait_req(64'h1000);
    do_ack();
    for (int b = 0; b < 3; b++) send_beat(64'h1000, b, -1);
    bus_respcyc = 1'b1;
    bus_resp = {wval(64'h101C), wval(64'h1018)};
    redirect_valid = 1'b1;
    redirect_pc = 64'h2004;
    #1;
    check("redirect_inst_valid", inst_valid, 0);
    check("redirect_respack", bus_respack, 1);
    tick();
    redirect_valid = 1'b0;
    bus_respcyc = 1'b0;
    check("flushed_inst_valid", inst_valid, 0);
    check("drain_no_req", bus_reqcyc, 0);
    for (int b = 4; b < 8; b++) send_beat(64'h1000, b, -1);
    inst_ready = 1'b1;
    push_exp(64'h2000, 1, 15);
    wait_req(64'h2000);
    do_ack();
    for (int b = 0; b < 8; b++) send_beat(64'h2000, b, -1);
    drain_wait();

    // zero word halts fetch
    do_reset(64'h1000);
    push_exp(64'h1000, 0, 4);
    wait_req(64'h1000);
    do_ack();
    for (int b = 0; b < 8; b++) send_beat(64'h1000, b, 5);
    seen = 0;
    repeat (20) begin
      tick();
      if (bus_reqcyc) seen = 1;
    end
    check("halt_no_req", 64'(seen), 0);
    check("halted", halted, 1);
    drain_wait();
    redirect_valid = 1'b1;
    redirect_pc = 64'h3000;
    tick();
    redirect_valid = 1'b0;
    check("halted_cleared", halted, 0);
    push_exp(64'h3000, 0, 15);
    wait_req(64'h3000);
    do_ack();
    for (int b = 0; b < 8; b++) send_beat(64'h3000, b, -1);
    drain_wait();

    // reset during RESP
    inst_ready = 1'b0;
    do_reset(64'h1000);
    wait_req(64'h1000);
    do_ack();
    for (int b = 0; b < 3; b++) send_beat(64'h1000, b, -1);
    reset = 1'b1;
    entry = 64'h4000;
    tick();
    tick();
    check("midrst_inst_valid", inst_valid, 0);
    check("midrst_reqcyc", bus_reqcyc, 0);
    check("midrst_req", bus_req, 0);
    check("midrst_tag", bus_reqtag, 0);
    check("midrst_halted", halted, 0);
    check("midrst_respack", bus_respack, 0);
    reset = 1'b0;
    #1;
    check("midrst_drain_no_req", bus_reqcyc, 0);
    for (int b = 3; b < 8; b++) send_beat(64'h1000, b, -1);
    check("stray_not_queued", inst_valid, 0);
    inst_ready = 1'b1;
    push_exp(64'h4000, 0, 15);
    wait_req(64'h4000);
    do_ack();
    for (int b = 0; b < 8; b++) send_beat(64'h4000, b, -1);
    drain_wait();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
